// File: rtl/full_adder_if.sv
// Operand/result bundle for full_adder. The master drives operands, the slave (the adder)
// returns the result and its valid.
interface full_adder_if #(
  parameter int WIDTH = 1
) ();
  logic [WIDTH-1:0] x;
  logic [WIDTH-1:0] y;
  logic             carry_in;
  logic             in_valid;
  logic [WIDTH-1:0] sum;
  logic             carry_out;
  logic             overflow;
  logic             out_valid;

  modport master (
    output x, y, carry_in, in_valid,
    input  sum, carry_out, overflow, out_valid
  );

  modport slave (
    input  x, y, carry_in, in_valid,
    output sum, carry_out, overflow, out_valid
  );
endinterface

// File: rtl/full_adder.sv
// Ripple-carry adder built from 1-bit cells. It has an optional one-stage result register
// that loads only on valid input.
module fa_cell (
  input  logic a_i,
  input  logic b_i,
  input  logic c_i,
  output logic s_o,
  output logic c_o
);
  assign s_o = a_i ^ b_i ^ c_i;
  assign c_o = (a_i & b_i) | (c_i & (a_i ^ b_i));
endmodule

module full_adder #(
  parameter int WIDTH      = 1,
  parameter bit REGISTERED = 1'b1
) (
  input  logic         clk,
  input  logic         rst,
  full_adder_if.slave  bus
);
  typedef struct packed {
    logic [WIDTH-1:0] sum;
    logic             co;
    logic             ov;
  } rsp_t;

  logic [WIDTH-1:0] s_d;
  rsp_t             rsp_d;

  // Each cell keeps its own carry nets so the chain is not one self-referencing vector.
  for (genvar i = 0; i < WIDTH; i++) begin : g_bit
    logic cin;
    logic cout;
    if (i == 0) begin : g_first
      assign cin = bus.carry_in;
    end else begin : g_rest
      assign cin = g_bit[i-1].cout;
    end
    fa_cell u_cell (
      .a_i (bus.x[i]),
      .b_i (bus.y[i]),
      .c_i (cin),
      .s_o (s_d[i]),
      .c_o (cout)
    );
  end

  assign rsp_d.sum = s_d;
  assign rsp_d.co  = g_bit[WIDTH-1].cout;
  assign rsp_d.ov  = g_bit[WIDTH-1].cin ^ g_bit[WIDTH-1].cout;

  if (REGISTERED) begin : g_reg
    rsp_t rsp_q;
    logic vld_q;

    // Result holds across invalid cycles; only the valid flag tracks in_valid every cycle.
    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        rsp_q <= '0;
        vld_q <= 1'b0;
      end else begin
        vld_q <= bus.in_valid;
        if (bus.in_valid) rsp_q <= rsp_d;
      end
    end

    assign bus.sum       = rsp_q.sum;
    assign bus.carry_out = rsp_q.co;
    assign bus.overflow  = rsp_q.ov;
    assign bus.out_valid = vld_q;
  end else begin : g_comb
    logic unused_ok;
    assign unused_ok     = clk ^ rst;
    assign bus.sum       = rsp_d.sum;
    assign bus.carry_out = rsp_d.co;
    assign bus.overflow  = rsp_d.ov;
    assign bus.out_valid = bus.in_valid;
  end
endmodule

// File: tb/tb_full_adder.sv
// Drives registered adders at widths 1, 8 and 64 and a combinational adder at width 8
// from one operand source. Every output is checked against an arithmetic reference.
module tb_full_adder;
  typedef struct packed {
    logic [65:0] r;   // {overflow, carry_out, sum[63:0]}
    logic        v;
  } exp_t;

  logic        clk, rst;
  logic [63:0] ax, ay;
  logic        aci, av;
  int          compared, mismatched;
  int          W [3] = '{1, 8, 64};
  exp_t        e [3];
  logic [63:0] tt [8] = '{64'd0, 64'd1, 64'd1, 64'd2, 64'd1, 64'd2, 64'd2, 64'd3};

  full_adder_if #(.WIDTH(1))  i1  ();
  full_adder_if #(.WIDTH(8))  i8  ();
  full_adder_if #(.WIDTH(64)) i64 ();
  full_adder_if #(.WIDTH(8))  i8c ();

  full_adder #(.WIDTH(1),  .REGISTERED(1'b1)) u1  (.clk(clk), .rst(rst), .bus(i1));
  full_adder #(.WIDTH(8),  .REGISTERED(1'b1)) u8  (.clk(clk), .rst(rst), .bus(i8));
  full_adder #(.WIDTH(64), .REGISTERED(1'b1)) u64 (.clk(clk), .rst(rst), .bus(i64));
  full_adder #(.WIDTH(8),  .REGISTERED(1'b0)) u8c (.clk(clk), .rst(rst), .bus(i8c));

  assign i1.x  = ax[0:0];  assign i1.y  = ay[0:0];  assign i1.carry_in  = aci; assign i1.in_valid  = av;
  assign i8.x  = ax[7:0];  assign i8.y  = ay[7:0];  assign i8.carry_in  = aci; assign i8.in_valid  = av;
  assign i64.x = ax;       assign i64.y = ay;       assign i64.carry_in = aci; assign i64.in_valid = av;
  assign i8c.x = ax[7:0];  assign i8c.y = ay[7:0];  assign i8c.carry_in = aci; assign i8c.in_valid = av;

  logic [63:0] o_sum [4];
  logic        o_co [4], o_ov [4], o_v [4];
  assign o_sum[0] = {63'd0, i1.sum};  assign o_co[0] = i1.carry_out;  assign o_ov[0] = i1.overflow;  assign o_v[0] = i1.out_valid;
  assign o_sum[1] = {56'd0, i8.sum};  assign o_co[1] = i8.carry_out;  assign o_ov[1] = i8.overflow;  assign o_v[1] = i8.out_valid;
  assign o_sum[2] = i64.sum;          assign o_co[2] = i64.carry_out; assign o_ov[2] = i64.overflow; assign o_v[2] = i64.out_valid;
  assign o_sum[3] = {56'd0, i8c.sum}; assign o_co[3] = i8c.carry_out; assign o_ov[3] = i8c.overflow; assign o_v[3] = i8c.out_valid;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Unsigned sum/carry from a wide add; overflow from whether the true signed sum fits w bits.
  function automatic logic [65:0] ref_add(input logic [63:0] a, input logic [63:0] b,
                                          input logic ci, input int w);
    logic [63:0]        m;
    logic [65:0]        u, r;
    logic signed [65:0] sa, sb, ts, hi, lo;
    m  = (w == 64) ? {64{1'b1}} : ((64'd1 << w) - 64'd1);
    u  = {2'b00, a & m} + {2'b00, b & m} + {65'd0, ci};
    sa = a[w-1] ? $signed({2'b11, a | ~m}) : $signed({2'b00, a & m});
    sb = b[w-1] ? $signed({2'b11, b | ~m}) : $signed({2'b00, b & m});
    ts = sa + sb + $signed({65'd0, ci});
    hi = $signed(66'd1 << (w - 1)) - 66'sd1;
    lo = -hi - 66'sd1;
    r        = '0;
    r[63:0]  = u[63:0] & m;
    r[64]    = u[w];
    r[65]    = (ts > hi) || (ts < lo);
    return r;
  endfunction

  task automatic chk(input string tag, input int k, input logic [63:0] obs, input logic [63:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s dut%0d observed=%h expected=%h", tag, k, obs, exp);
    end
  endtask

  task automatic check_all(input string tag);
    logic [65:0] r;
    for (int k = 0; k < 3; k++) begin
      chk({tag, "/sum"}, k, o_sum[k], e[k].r[63:0]);
      chk({tag, "/co"},  k, {63'd0, o_co[k]}, {63'd0, e[k].r[64]});
      chk({tag, "/ov"},  k, {63'd0, o_ov[k]}, {63'd0, e[k].r[65]});
      chk({tag, "/vld"}, k, {63'd0, o_v[k]},  {63'd0, e[k].v});
    end
    r = ref_add(ax, ay, aci, 8);
    chk({tag, "/sum"}, 3, o_sum[3], r[63:0]);
    chk({tag, "/co"},  3, {63'd0, o_co[3]}, {63'd0, r[64]});
    chk({tag, "/ov"},  3, {63'd0, o_ov[3]}, {63'd0, r[65]});
    chk({tag, "/vld"}, 3, {63'd0, o_v[3]},  {63'd0, av});
  endtask

  task automatic cycle(input string tag);
    @(posedge clk);
    for (int k = 0; k < 3; k++) begin
      if (rst) e[k] = '0;
      else begin
        e[k].v = av;
        if (av) e[k].r = ref_add(ax, ay, aci, W[k]);
      end
    end
    #1;
    check_all(tag);
  endtask

  initial begin
    compared = 0; mismatched = 0;
    for (int k = 0; k < 3; k++) e[k] = '0;
    rst = 1'b1; av = 1'b1; ax = 64'h5; ay = 64'h3; aci = 1'b1;
    #1 check_all("reset_async");
    cycle("reset_discard");
    rst = 1'b0; av = 1'b0;
    cycle("post_reset_idle");

    for (int i = 0; i < 8; i++) begin
      aci = i[2]; ax = {63'd0, i[1]}; ay = {63'd0, i[0]}; av = 1'b1;
      cycle("truth_table");
      chk("tt_w1", 0, {62'd0, o_co[0], o_sum[0][0]}, tt[i]);
    end

    aci = 1'b1; ax = 64'd1; ay = 64'd1;
    cycle("w1_111");
    chk("w1_111_ov", 0, {62'd0, o_co[0], o_ov[0]}, 64'd2);
    aci = 1'b1; ax = 64'd0; ay = 64'd0;
    cycle("w1_100");
    chk("w1_100_ov", 0, {61'd0, o_sum[0][0], o_co[0], o_ov[0]}, 64'd5);

    aci = 1'b1; ax = 64'hFF; ay = 64'h00;
    cycle("w8_ff_wrap");
    chk("w8_ff_wrap", 1, {55'd0, o_co[1], o_sum[1][7:0]}, 64'h100);
    aci = 1'b0; ax = 64'h7F; ay = 64'h01;
    cycle("w8_7f_ovf");
    chk("w8_7f_ovf", 1, {54'd0, o_ov[1], o_co[1], o_sum[1][7:0]}, 64'h280);

    ax = {64{1'b1}}; ay = {64{1'b1}}; aci = 1'b1;
    cycle("all_ones");
    chk("all_ones64", 2, o_sum[2], {64{1'b1}});

    av = 1'b1; ax = 64'h10; ay = 64'h20; aci = 1'b0;
    cycle("vld_toggle1");
    av = 1'b0; ax = 64'h55; ay = 64'h66;
    cycle("vld_toggle0");
    chk("hold_sum", 1, o_sum[1], 64'h30);
    av = 1'b1; ax = 64'h01; ay = 64'h02;
    cycle("vld_toggle1b");
    chk("resume_sum", 1, o_sum[1], 64'h03);

    #2 rst = 1'b1;
    for (int k = 0; k < 3; k++) e[k] = '0;
    #1 check_all("rst_midstream");
    #1 rst = 1'b0; av = 1'b0;
    cycle("no_stale");
    av = 1'b1; ax = 64'd3; ay = 64'd4; aci = 1'b0;
    cycle("after_rst");
    chk("after_rst_sum", 1, {62'd0, o_v[1], 1'b0} | (o_sum[1] << 2), 64'h1E);

    for (int n = 0; n < 10000; n++) begin
      ax  = ($urandom_range(0, 7) == 0) ? {64{1'b1}} : {$urandom, $urandom};
      ay  = ($urandom_range(0, 7) == 0) ? {64{1'b1}} : {$urandom, $urandom};
      aci = 1'(($urandom_range(0, 1)));
      av  = ($urandom_range(0, 3) != 0);
      rst = ($urandom_range(0, 199) == 0);
      cycle("random");
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule
